// File: rtl/instr_queue.sv
// Decoupling instruction queue between fetch and decode.
// Holds DEPTH {pc, instruction} entries and presents them to decode in order
// over a valid/ready handshake. A flush discards every entry.
// Optional J/JAL predecode is enabled by defining INSTR_QUEUE_PREDECODE_EN.
// It produces an early redirect and squashes wrong-path fetches until the
// jump target arrives.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [29:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [29:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    input  logic             flush,
    output logic [PTR_W:0]   level,
    output logic             redirect_en,
    output logic [29:0]      redirect_addr
);

    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

    logic [61:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [61:0]      head;
    logic             enq;
    logic             deq;
    logic             store;

    // Full and empty come from the occupancy count, never from pointer compare.
    assign in_ready  = (level_q != FULL_LEVEL);
    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign head      = mem_q[rd_ptr_q];

    // An empty queue shows a NOP rather than stale storage contents.
    assign out_pc    = out_valid ? head[61:32] : 30'd0;
    assign out_instr = out_valid ? head[31:0]  : 32'd0;

    // Flush wins over both handshakes, so the incoming entry is dropped.
    assign enq = in_valid & in_ready & ~flush;
    assign deq = out_valid & out_ready & ~flush;

`ifdef INSTR_QUEUE_PREDECODE_EN
    logic        squash_q, squash_d;
    logic        redirect_en_q, redirect_en_d;
    logic [29:0] redirect_addr_q, redirect_addr_d;
    logic        is_jump;
    logic        pc_hit;
    logic        jump_hit;

    // Opcode 6'b000010 (J) or 6'b000011 (JAL).
    assign is_jump  = (in_instr[31:27] == 5'b00001);
    assign pc_hit   = (in_pc == redirect_addr_q);
    // While squashing, wrong-path entries are accepted but not written.
    assign store    = enq & (~squash_q | pc_hit);
    // A jump seen while squash is already active is ignored.
    assign jump_hit = store & ~squash_q & is_jump;

    assign redirect_en   = redirect_en_q & ~flush;
    assign redirect_addr = redirect_addr_q;

    // Predecode next state: arm squash on a jump, clear it on the target.
    always_comb begin
        squash_d        = squash_q;
        redirect_en_d   = jump_hit;
        redirect_addr_d = redirect_addr_q;
        if (flush) begin
            squash_d = 1'b0;
        end else if (jump_hit) begin
            squash_d        = 1'b1;
            redirect_addr_d = {in_pc[29:26], in_instr[25:0]};
        end else if (squash_q && enq && pc_hit) begin
            squash_d = 1'b0;
        end
    end

    // Predecode state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_q        <= 1'b0;
            redirect_en_q   <= 1'b0;
            redirect_addr_q <= 30'd0;
        end else begin
            squash_q        <= squash_d;
            redirect_en_q   <= redirect_en_d;
            redirect_addr_q <= redirect_addr_d;
        end
    end
`else
    assign store         = enq;
    assign redirect_en   = 1'b0;
    assign redirect_addr = 30'd0;
`endif

    // Pointer and occupancy next state; pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({store, deq})
                2'b10:   level_d = level_q + (PTR_W+1)'(1);
                2'b01:   level_d = level_q - (PTR_W+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; contents need no reset because level gates the outputs.
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= {in_pc, in_instr};
    end

endmodule
